// File: rtl/reg_writeback_unit.sv
// Register-file write-port owner: merges never-stalled ALU results with buffered load
// responses, squashes stale loads on write-after-write, and reports pending-load hazards.
module reg_writeback_unit #(
    parameter int DATA_W       = 24,
    parameter int ADDR_W       = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_valid,
    input  logic [ADDR_W-1:0]    alu_dest,
    input  logic [DATA_W-1:0]    alu_data,
    input  logic                 mem_valid,
    output logic                 mem_ready,
    input  logic [ADDR_W-1:0]    mem_dest,
    input  logic [DATA_W-1:0]    mem_data,
    output logic                 reg_write_en,
    output logic [ADDR_W-1:0]    reg_write_dest,
    output logic [DATA_W-1:0]    reg_write_data,
    output logic [2**ADDR_W-1:0] busy_mask,
    output logic                 stall_req
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NREG  = 2**ADDR_W;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    logic [DATA_W-1:0]     fifo_data_q [FIFO_DEPTH];
    logic [DATA_W-1:0]     fifo_data_d [FIFO_DEPTH];
    logic [ADDR_W-1:0]     fifo_dest_q [FIFO_DEPTH];
    logic [ADDR_W-1:0]     fifo_dest_d [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_vld_q, fifo_vld_d;
    logic [FIFO_DEPTH-1:0] fifo_kill_q, fifo_kill_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [STV_W-1:0]      starve_q, starve_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]     wr_dest_q, wr_dest_d;
    logic [DATA_W-1:0]     wr_data_q, wr_data_d;

    logic alu_wr;
    logic fifo_empty;
    logic push;
    logic pop;

    function automatic logic [STV_W-1:0] sat_inc(input logic [STV_W-1:0] v);
        if (v >= STV_W'(STARVE_LIMIT)) begin
            return STV_W'(STARVE_LIMIT);
        end
        return v + STV_W'(1);
    endfunction

    assign mem_ready      = !rst && (count_q < CNT_W'(FIFO_DEPTH));
    assign reg_write_en   = wr_en_q;
    assign reg_write_dest = wr_dest_q;
    assign reg_write_data = wr_data_q;
    assign stall_req      = (starve_q == STV_W'(STARVE_LIMIT)) && !fifo_empty;

    always_comb begin
        alu_wr     = alu_valid && (alu_dest != '0);
        fifo_empty = (count_q == '0);
        pop        = !alu_wr && !fifo_empty;
        // Loads to $zero complete the handshake but never occupy a slot.
        push       = mem_valid && mem_ready && (mem_dest != '0);
    end

    always_comb begin
        fifo_data_d = fifo_data_q;
        fifo_dest_d = fifo_dest_q;
        fifo_vld_d  = fifo_vld_q;
        fifo_kill_d = fifo_kill_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        wr_en_d     = 1'b0;
        wr_dest_d   = wr_dest_q;
        wr_data_d   = wr_data_q;

        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (alu_wr && fifo_vld_q[i] && (fifo_dest_q[i] == alu_dest)) begin
                fifo_kill_d[i] = 1'b1;
            end
        end

        if (alu_wr) begin
            wr_en_d   = 1'b1;
            wr_dest_d = alu_dest;
            wr_data_d = alu_data;
        end else if (pop) begin
            if (!fifo_kill_q[rd_ptr_q]) begin
                wr_en_d   = 1'b1;
                wr_dest_d = fifo_dest_q[rd_ptr_q];
                wr_data_d = fifo_data_q[rd_ptr_q];
            end
        end

        if (pop) begin
            fifo_vld_d[rd_ptr_q]  = 1'b0;
            fifo_kill_d[rd_ptr_q] = 1'b0;
            rd_ptr_d              = rd_ptr_q + PTR_W'(1);
        end

        // A same-cycle ALU write to the same register is younger than the arriving load.
        if (push) begin
            fifo_data_d[wr_ptr_q] = mem_data;
            fifo_dest_d[wr_ptr_q] = mem_dest;
            fifo_vld_d[wr_ptr_q]  = 1'b1;
            fifo_kill_d[wr_ptr_q] = alu_wr && (mem_dest == alu_dest);
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (fifo_empty || pop) begin
            starve_d = '0;
        end else begin
            starve_d = sat_inc(starve_q);
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (fifo_vld_q[i] && !fifo_kill_q[i]) begin
                busy_mask[fifo_dest_q[i]] = 1'b1;
            end
        end
    end

    // Control and write-port state
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_vld_q  <= '0;
            fifo_kill_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            starve_q    <= '0;
            wr_en_q     <= 1'b0;
            wr_dest_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            fifo_vld_q  <= fifo_vld_d;
            fifo_kill_q <= fifo_kill_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            starve_q    <= starve_d;
            wr_en_q     <= wr_en_d;
            wr_dest_q   <= wr_dest_d;
            wr_data_q   <= wr_data_d;
        end
    end

    // Payload storage: only meaningful where the matching valid bit is set
    always_ff @(posedge clk) begin
        fifo_data_q <= fifo_data_d;
        fifo_dest_q <= fifo_dest_d;
    end

    logic unused_nreg;
    assign unused_nreg = (NREG == 0);

endmodule
